// File: rtl/serial_frame_pkg.sv
// Shared encodings and line-level constants for the serial frame receiver.
package serial_frame_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;
endpackage

// File: rtl/serial_frame_rx_sipo.sv
// N-bit serial-in/parallel-out shifter (LSB arrives first, ends at bit 0).
// With PARITY_CHK_EN defined it also keeps a running XOR of the shifted bits.
module serial_frame_rx_sipo #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         s_in,
    output logic [N-1:0] data
`ifdef PARITY_CHK_EN
    ,
    output logic         par
`endif
);
    logic [N-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clr)
            data_d = '0;
        else if (shift_en)
            data_d = {s_in, data_q[N-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign data = data_q;

`ifdef PARITY_CHK_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (clr)
            par_d = 1'b0;
        else if (shift_en)
            par_d = par_q ^ s_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end

    assign par = par_q;
`endif
endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start(0), N data bits LSB-first, [even parity], stop(1).
// Define PARITY_CHK_EN to expect and check the parity bit.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_in,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         frame_err,
    output logic         parity_err,
    output logic         busy
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               parity_err_q, parity_err_d;
    logic               busy_q, busy_d;
    logic               shift_en, clr, par_fault;
    logic [N-1:0]       shreg;

`ifdef PARITY_CHK_EN
    logic run_par, rx_par_q, rx_par_d;

    serial_frame_rx_sipo #(.N(N)) u_sipo (
        .clk(clk), .rst(reset), .clr(clr), .shift_en(shift_en),
        .s_in(s_in), .data(shreg), .par(run_par)
    );

    // Even parity: the received bit must equal the XOR of the data bits.
    assign par_fault = rx_par_q ^ run_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_par_q <= 1'b0;
        else       rx_par_q <= rx_par_d;
    end
`else
    serial_frame_rx_sipo #(.N(N)) u_sipo (
        .clk(clk), .rst(reset), .clr(clr), .shift_en(shift_en),
        .s_in(s_in), .data(shreg)
    );

    assign par_fault = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        shift_en     = 1'b0;
        clr          = 1'b0;
`ifdef PARITY_CHK_EN
        rx_par_d     = rx_par_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_in == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d = '0;
`ifdef PARITY_CHK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_CHK_EN
            PARITY: begin
                rx_par_d = s_in;
                state_d  = STOP;
            end
`endif
            STOP: begin
                // A low stop bit only flags an error; it never starts a new frame.
                if (s_in == STOP_BIT && !par_fault) begin
                    data_out_d   = shreg;
                    data_valid_d = 1'b1;
                end else begin
                    frame_err_d  = (s_in != STOP_BIT);
                    parity_err_d = par_fault;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (N=8); honours PARITY_CHK_EN.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    localparam int N = 8;
`ifdef PARITY_CHK_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = N + 2 + PB;

    typedef struct {
        logic         dv;
        logic         fe;
        logic         pe;
        logic [N-1:0] dout;
    } exp_t;

    exp_t sb[$];

    logic         clk = 1'b0;
    logic         rst;
    logic         s_in;
    logic [N-1:0] data_out;
    logic         data_valid, frame_err, parity_err, busy;

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           dv_cnt = 0, fe_cnt = 0, pe_cnt = 0;
    logic [N-1:0] exp_dout = '0;

    serial_frame_rx #(.N(N), .CNT_W(4)) dut (
        .clk(clk), .reset(rst), .s_in(s_in),
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (data_valid) dv_cnt++;
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        s_in = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(IDLE_LVL);
    endtask

    // Drives one frame, pushes the expectation, then checks the pulse cycle.
    task automatic send_frame(input logic [N-1:0] d, input logic stop,
                              input logic par_bad, input string tag,
                              output int t_stop);
        exp_t e, got;
        logic p;
        p    = ^d;
        e.fe = (stop != STOP_BIT);
        e.pe = (PB != 0) && par_bad;
        e.dv = !e.fe && !e.pe;
        if (e.dv) exp_dout = d;
        e.dout = exp_dout;
        sb.push_back(e);

        send_bit(START_BIT);
        for (int i = 0; i < N; i++) send_bit(d[i]);
`ifdef PARITY_CHK_EN
        send_bit(par_bad ? ~p : p);
`endif
        send_bit(stop);
        t_stop = cyc;

        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s sb_empty: no expectation queued", tag);
        end else begin
            got = sb.pop_front();
            n_cmp++;
            if (data_valid !== got.dv) begin
                n_err++;
                $display("FAIL %s data_valid: got %b want %b", tag, data_valid, got.dv);
            end
            n_cmp++;
            if (frame_err !== got.fe) begin
                n_err++;
                $display("FAIL %s frame_err: got %b want %b", tag, frame_err, got.fe);
            end
            n_cmp++;
            if (parity_err !== got.pe) begin
                n_err++;
                $display("FAIL %s parity_err: got %b want %b", tag, parity_err, got.pe);
            end
            n_cmp++;
            if (data_out !== got.dout) begin
                n_err++;
                $display("FAIL %s data_out: got %h want %h", tag, data_out, got.dout);
            end
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        s_in = IDLE_LVL;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({data_out, data_valid, frame_err, parity_err, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got dout=%h dv=%b fe=%b pe=%b busy=%b want all 0",
                     data_out, data_valid, frame_err, parity_err, busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_bit(IDLE_LVL);
            n_cmp++;
            if (busy !== 1'b0 || data_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
                n_err++;
                $display("FAIL idle_high cycle %0d: busy=%b dv=%b fe=%b pe=%b want 0",
                         i, busy, data_valid, frame_err, parity_err);
            end
        end
    endtask

    task automatic test_good_frame;
        int t, dv0;
        dv0 = dv_cnt;
        send_frame(8'hA5, STOP_BIT, 1'b0, "good_a5", t);
        idle(2);
        n_cmp++;
        if (dv_cnt - dv0 !== 1) begin
            n_err++;
            $display("FAIL good_a5 pulse_count: got %0d want 1", dv_cnt - dv0);
        end
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL good_a5 pulse_clear: got %b want 0", data_valid);
        end
    endtask

    task automatic test_frame_err;
        int t, fe0;
        fe0 = fe_cnt;
        send_frame(8'hA5, ~STOP_BIT, 1'b0, "bad_stop", t);
        idle(1);
        n_cmp++;
        if (fe_cnt - fe0 !== 1) begin
            n_err++;
            $display("FAIL bad_stop pulse_count: got %0d want 1", fe_cnt - fe0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bad_stop rearm_idle: busy got %b want 0", busy);
        end
        send_frame(8'h3C, STOP_BIT, 1'b0, "after_err_3c", t);
        idle(2);
    endtask

    task automatic test_back_to_back;
        int t1, t2, dv0;
        dv0 = dv_cnt;
        send_frame(8'h01, STOP_BIT, 1'b0, "b2b_01", t1);
        send_frame(8'hFF, STOP_BIT, 1'b0, "b2b_ff", t2);
        idle(2);
        n_cmp++;
        if (t2 - t1 !== FL) begin
            n_err++;
            $display("FAIL b2b spacing: got %0d want %0d", t2 - t1, FL);
        end
        n_cmp++;
        if (dv_cnt - dv0 !== 2) begin
            n_err++;
            $display("FAIL b2b pulse_count: got %0d want 2", dv_cnt - dv0);
        end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] d;
        int t, dv0, fe0;
        d = 8'h5A;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_bit(START_BIT);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_frame busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || data_out !== '0 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid immediate: busy=%b dout=%h dv=%b fe=%b want 0",
                     busy, data_out, data_valid, frame_err);
        end
        @(negedge clk);
        rst      = 1'b0;
        exp_dout = '0;
        sb.delete();
        idle(3);
        n_cmp++;
        if (dv_cnt != dv0 || fe_cnt != fe0) begin
            n_err++;
            $display("FAIL reset_mid no_pulse: dv delta %0d fe delta %0d want 0",
                     dv_cnt - dv0, fe_cnt - fe0);
        end
        send_frame(8'h5A, STOP_BIT, 1'b0, "after_reset_5a", t);
        idle(2);
    endtask

    task automatic test_line_low;
        int dv0, fe0, pe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        for (int i = 0; i < 3 * FL; i++) send_bit(1'b0);
        idle(2);
        n_cmp++;
        if (fe_cnt - fe0 !== 3) begin
            n_err++;
            $display("FAIL line_low frame_err_count: got %0d want 3", fe_cnt - fe0);
        end
        n_cmp++;
        if (dv_cnt != dv0 || pe_cnt != pe0) begin
            n_err++;
            $display("FAIL line_low other_pulses: dv %0d pe %0d want 0", dv_cnt - dv0, pe_cnt - pe0);
        end
        n_cmp++;
        if (data_out !== exp_dout) begin
            n_err++;
            $display("FAIL line_low data_hold: got %h want %h", data_out, exp_dout);
        end
    endtask

`ifdef PARITY_CHK_EN
    task automatic test_parity;
        int t, pe0;
        pe0 = pe_cnt;
        send_frame(8'h07, STOP_BIT, 1'b1, "parity_bad_07", t);
        idle(1);
        n_cmp++;
        if (pe_cnt - pe0 !== 1) begin
            n_err++;
            $display("FAIL parity_bad pulse_count: got %0d want 1", pe_cnt - pe0);
        end
        send_frame(8'h07, STOP_BIT, 1'b0, "parity_ok_07", t);
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_line_low();
`ifdef PARITY_CHK_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
